// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared encodings and helpers for the two-input round-robin mux arbiter.
// Requesters are identified by the sel value that routes them (A=0, B=1).
package mux2_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_GA   = 2'd2,
        ST_GB   = 2'd3
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int unsigned TURN_W = 4;

    // Sole requester wins; on a tie the side that did not win last time wins.
    function automatic logic pick_winner(input logic req_a, input logic req_b,
                                         input logic last_winner);
        logic w;
        if (req_a && !req_b)
            w = SEL_A;
        else if (req_b && !req_a)
            w = SEL_B;
        else
            w = ~last_winner;
        return w;
    endfunction

    function automatic arb_state_t grant_state(input logic side);
        return (side == SEL_A) ? ST_GA : ST_GB;
    endfunction

endpackage

// File: rtl/mux2_arb_cnt.sv
// Loadable saturating up/down counter with a compare flag at a fixed value.
// Load wins over counting; up stops at SAT, down stops at zero.
module mux2_arb_cnt
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int unsigned W   = 8,
    parameter int unsigned SAT = 255,
    parameter int unsigned TC  = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         up,
    input  logic         down,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] SAT_V = W'(SAT);
    localparam logic [W-1:0] TC_V  = W'(TC);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (up && (count_q != SAT_V)) begin
            count_q <= count_q + W'(1);
        end else if (down && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign count = count_q;
    assign tc    = (count_q == TC_V);

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin owner of a shared mux2_1 select: break-before-make turnaround on
// every sel change and a hold limit that preempts an owner while the other waits.
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD   = 16,
    parameter int unsigned TURNAROUND = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic last_a,
    input  logic last_b,
    output logic sel,
    output logic gnt_a,
    output logic gnt_b,
    output logic busy,
    output logic preempt
);

    arb_state_t state, state_next;
    logic sel_q, sel_next;
    logic last_winner, lw_next;
    logic dropped_q, dropped_next;
    logic preempt_q, preempt_next;

    logic winner;
    logic req_sel;
    logic in_grant, next_in_grant;

    logic              hold_load, hold_up, hold_limit;
    logic [CNT_W-1:0]  hold_cnt;
    logic              turn_load, turn_dec, turn_done;
    logic [TURN_W-1:0] turn_cnt;

    mux2_arb_cnt #(
        .W   (CNT_W),
        .SAT (MAX_HOLD),
        .TC  (MAX_HOLD - 1)
    ) u_hold_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val ('0),
        .up       (hold_up),
        .down     (1'b0),
        .count    (hold_cnt),
        .tc       (hold_limit)
    );

    mux2_arb_cnt #(
        .W   (TURN_W),
        .SAT ((1 << TURN_W) - 1),
        .TC  (0)
    ) u_turn_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (turn_load),
        .load_val (TURN_W'(TURNAROUND - 1)),
        .up       (1'b0),
        .down     (turn_dec),
        .count    (turn_cnt),
        .tc       (turn_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            sel_q       <= SEL_A;
            last_winner <= SEL_B;
            dropped_q   <= 1'b0;
            preempt_q   <= 1'b0;
        end else begin
            state       <= state_next;
            sel_q       <= sel_next;
            last_winner <= lw_next;
            dropped_q   <= dropped_next;
            preempt_q   <= preempt_next;
        end
    end

    always_comb begin
        state_next   = state;
        sel_next     = sel_q;
        lw_next      = last_winner;
        dropped_next = dropped_q;
        preempt_next = 1'b0;
        turn_load    = 1'b0;
        turn_dec     = 1'b0;
        winner       = pick_winner(req_a, req_b, last_winner);
        // During TURN sel already names the pending winner.
        req_sel      = (sel_q == SEL_A) ? req_a : req_b;

        case (state)
            ST_IDLE: begin
                dropped_next = 1'b0;
                if (req_a || req_b) begin
                    if (winner == sel_q) begin
                        state_next = grant_state(winner);
                    end else begin
                        sel_next   = winner;
                        turn_load  = 1'b1;
                        state_next = ST_TURN;
                    end
                end
            end
            ST_TURN: begin
                turn_dec = 1'b1;
                if (!req_sel)
                    dropped_next = 1'b1;
                if (turn_done)
                    state_next = (req_sel && !dropped_q) ? grant_state(sel_q) : ST_IDLE;
            end
            ST_GA: begin
                if (last_a || !req_a || (hold_limit && req_b)) begin
                    state_next   = ST_IDLE;
                    lw_next      = SEL_A;
                    // Still requesting with no last: only the hold limit ended it.
                    preempt_next = req_a && !last_a;
                end
            end
            ST_GB: begin
                if (last_b || !req_b || (hold_limit && req_a)) begin
                    state_next   = ST_IDLE;
                    lw_next      = SEL_B;
                    preempt_next = req_b && !last_b;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign in_grant      = (state == ST_GA) || (state == ST_GB);
    assign next_in_grant = (state_next == ST_GA) || (state_next == ST_GB);
    assign hold_load     = !(in_grant && next_in_grant);
    assign hold_up       = in_grant;

    assign sel     = sel_q;
    assign gnt_a   = (state == ST_GA);
    assign gnt_b   = (state == ST_GB);
    assign busy    = (state != ST_IDLE);
    assign preempt = preempt_q;

endmodule
